// File: rtl/safe_status_panel_if.sv
// Bundle between the safe's event stream / log reader and the status panel.
// The master side drives events, acknowledge and log-ready; the slave side is the panel.
interface safe_status_panel_if;
  logic [2:0] event_i;
  logic       event_valid_i;
  logic       ack_i;
  logic       log_ready_i;
  logic [2:0] log_data_o;
  logic       log_valid_o;
  logic       led_locked_o;
  logic       led_check_o;
  logic       led_open_o;
  logic       alarm_o;
  logic       overflow_o;

  modport master (
    output event_i, event_valid_i, ack_i, log_ready_i,
    input  log_data_o, log_valid_o, led_locked_o, led_check_o,
    input  led_open_o, alarm_o, overflow_o
  );

  modport slave (
    input  event_i, event_valid_i, ack_i, log_ready_i,
    output log_data_o, log_valid_o, led_locked_o, led_check_o,
    output led_open_o, alarm_o, overflow_o
  );
endinterface

// File: rtl/safe_status_panel.sv
// Front-panel tracker for the safe controller's event stream: panel FSM with
// wrong-code alarm, blinking check LED and a first-word-fall-through event log.
module safe_status_panel #(
  parameter int FIFO_DEPTH   = 4,
  parameter int FAIL_LIMIT   = 3,
  parameter int BLINK_CYCLES = 500
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  safe_status_panel_if.slave pnl
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FAIL_LIMIT + 1);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [FW-1:0] FAIL_MAX  = FW'(FAIL_LIMIT);
  localparam logic [FW-1:0] FAIL_ONE  = FW'(1);
  localparam logic [FW-1:0] FAIL_ZERO = FW'(0);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_ONE = BW'(1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] EV_IN_LOCK   = 3'd0;
  localparam logic [2:0] EV_IN_CHECK  = 3'd1;
  localparam logic [2:0] EV_IN_OPEN   = 3'd2;
  localparam logic [2:0] EV_PASS_OK   = 3'd3;
  localparam logic [2:0] EV_PASS_FAIL = 3'd4;
  localparam logic [2:0] EV_TIMEOUT   = 3'd5;
  localparam logic [2:0] EV_CLOSE     = 3'd6;
  localparam logic [2:0] EV_RESERVED  = 3'd7;

  typedef enum logic [1:0] {
    P_LOCKED = 2'd0,
    P_CHECK  = 2'd1,
    P_OPEN   = 2'd2,
    P_ALARM  = 2'd3
  } state_t;

  function automatic logic [FW-1:0] fail_sat_inc(input logic [FW-1:0] v);
    logic [FW-1:0] r;
    if (v >= FAIL_MAX) begin
      r = FAIL_MAX;
    end else begin
      r = v + FAIL_ONE;
    end
    return r;
  endfunction

  logic          prev_valid_r;
  logic [2:0]    prev_code_r;
  logic          accept_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [FW-1:0] fail_cnt_r;
  logic [FW-1:0] fail_cnt_next_s;
  logic          enter_check_s;
  logic [BW-1:0] blink_cnt_r;
  logic [BW-1:0] blink_cnt_next_s;
  logic          blink_phase_r;
  logic          blink_phase_next_s;

  logic          led_locked_r;
  logic          led_check_r;
  logic          led_open_r;
  logic          alarm_r;
  logic          overflow_r;

  logic [2:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          log_valid_r;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Edge-detect the event stream so a level-held code is accepted once.
  always_comb begin
    accept_s = 1'b0;
    if (pnl.event_valid_i && (pnl.event_i != EV_RESERVED) &&
        (!prev_valid_r || (pnl.event_i != prev_code_r))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Previous-sample registers feeding the edge detector.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_valid_r <= 1'b0;
      prev_code_r  <= 3'd0;
    end else begin
      prev_valid_r <= pnl.event_valid_i;
      prev_code_r  <= pnl.event_i;
    end
  end

  // Panel next-state and fail counter; in alarm only ack matters.
  always_comb begin
    state_next_s    = state_r;
    fail_cnt_next_s = fail_cnt_r;
    enter_check_s   = 1'b0;
    if (state_r == P_ALARM) begin
      if (pnl.ack_i) begin
        state_next_s    = P_LOCKED;
        fail_cnt_next_s = FAIL_ZERO;
      end else begin
        state_next_s = P_ALARM;
      end
    end else if (accept_s) begin
      case (pnl.event_i)
        EV_IN_LOCK, EV_TIMEOUT, EV_CLOSE: state_next_s = P_LOCKED;
        EV_IN_CHECK: begin
          state_next_s  = P_CHECK;
          enter_check_s = 1'b1;
        end
        EV_IN_OPEN: state_next_s = P_OPEN;
        EV_PASS_OK: begin
          state_next_s    = P_OPEN;
          fail_cnt_next_s = FAIL_ZERO;
        end
        EV_PASS_FAIL: begin
          fail_cnt_next_s = fail_sat_inc(fail_cnt_r);
          if (fail_cnt_next_s == FAIL_MAX) begin
            state_next_s = P_ALARM;
          end else begin
            state_next_s = P_LOCKED;
          end
        end
        default: state_next_s = state_r;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Blink divider restarts on every entry into checking.
  always_comb begin
    blink_cnt_next_s   = blink_cnt_r;
    blink_phase_next_s = blink_phase_r;
    if (enter_check_s) begin
      blink_cnt_next_s   = BLINK_ZERO;
      blink_phase_next_s = 1'b1;
    end else if (state_r == P_CHECK) begin
      if (blink_cnt_r == BLINK_MAX) begin
        blink_cnt_next_s   = BLINK_ZERO;
        blink_phase_next_s = ~blink_phase_r;
      end else begin
        blink_cnt_next_s = blink_cnt_r + BLINK_ONE;
      end
    end else begin
      blink_cnt_next_s   = blink_cnt_r;
      blink_phase_next_s = blink_phase_r;
    end
  end

  // Panel FSM with indicator outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r       <= P_LOCKED;
      fail_cnt_r    <= FAIL_ZERO;
      blink_cnt_r   <= BLINK_ZERO;
      blink_phase_r <= 1'b1;
      led_locked_r  <= 1'b1;
      led_check_r   <= 1'b0;
      led_open_r    <= 1'b0;
      alarm_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      fail_cnt_r    <= fail_cnt_next_s;
      blink_cnt_r   <= blink_cnt_next_s;
      blink_phase_r <= blink_phase_next_s;
      led_locked_r  <= (state_next_s == P_LOCKED) || (state_next_s == P_CHECK);
      led_check_r   <= (state_next_s == P_CHECK) && blink_phase_next_s;
      led_open_r    <= (state_next_s == P_OPEN);
      alarm_r       <= (state_next_s == P_ALARM);
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  always_comb begin
    full_s = (count_r == CNT_FULL);
    pop_s  = log_valid_r && pnl.log_ready_i;
    push_s = accept_s && (!full_s || pop_s);
    drop_s = accept_s && full_s && !pop_s;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Log FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 3'd0;
      end
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      log_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pnl.event_i;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_next_s;
      log_valid_r <= (count_next_s != CNT_ZERO);
    end
  end

  // Sticky overflow; a drop in the same cycle as ack keeps it set.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (pnl.ack_i) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign pnl.log_data_o   = log_valid_r ? mem_r[rd_ptr_r] : 3'd0;
  assign pnl.log_valid_o  = log_valid_r;
  assign pnl.led_locked_o = led_locked_r;
  assign pnl.led_check_o  = led_check_r;
  assign pnl.led_open_o   = led_open_r;
  assign pnl.alarm_o      = alarm_r;
  assign pnl.overflow_o   = overflow_r;

endmodule
